// File: rtl/axi_common_pkg.sv
// Shared AXI definitions used by every AXI/AXI-Lite block.
//   resp_t : xRESP encodings (OKAY, EXOKAY, SLVERR, DECERR)
//   prot_t : xPROT field
package axi_common;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef logic [2:0] prot_t;

endpackage

// File: rtl/axi_lite_regbank_pkg.sv
// Constants shared by the AXI-Lite register bank and its decoder.
// Build option: AXI_LITE_REGBANK_DECERR_EN selects DECERR (defined) or
// OKAY (undefined) as the response to out-of-range accesses.
package axi_lite_regbank_pkg;
  import axi_common::*;

`ifdef AXI_LITE_REGBANK_DECERR_EN
  localparam resp_t OOR_RESP = DECERR;
`else
  localparam resp_t OOR_RESP = OKAY;
`endif

  localparam int BYTE_W = 8;

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle carrying its own clock and active-low reset.
//   clk, rstn          : channel clock / async active-low reset
//   aw_*, w_*, b_*     : write address, write data, write response
//   ar_*, r_*          : read address, read data
// Modports: master (initiator side), slave (target side).
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  axi_common::prot_t     aw_prot;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic                  b_valid;
  logic                  b_ready;
  axi_common::resp_t     b_resp;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  axi_common::prot_t     ar_prot;

  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  axi_common::resp_t     r_resp;

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb,    input w_ready,
    input  b_valid, b_resp,            output b_ready,
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    input  r_valid, r_data, r_resp,    output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot, output aw_ready,
    input  w_valid, w_data, w_strb,    output w_ready,
    output b_valid, b_resp,            input  b_ready,
    input  ar_valid, ar_addr, ar_prot, output ar_ready,
    output r_valid, r_data, r_resp,    input  r_ready
  );

endinterface

// File: rtl/axi_lite_regbank_decode.sv
// Combinational address decoder for the register bank.
//   addr     : byte address from AW or AR
//   index    : register index (valid only when in_range)
//   in_range : addr >= BASE_ADDR and the word index is below NUM_REGS
// Sub-word address bits are ignored.
module axi_lite_regbank_decode #(
  parameter int                    ADDR_WIDTH = 48,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int                   IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  in_range
);
  localparam int LSB = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // Below BASE_ADDR the subtraction wraps; the >= guard rejects it.
  assign offset   = addr - BASE_ADDR;
  assign word     = offset >> LSB;
  assign in_range = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
  assign index    = word[IDX_W-1:0];

  logic unused_lsb;
  assign unused_lsb = ^offset[LSB-1:0];

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI-Lite slave register bank: NUM_REGS read/write registers of
// DATA_WIDTH bits, byte-strobed writes, contents exported on regs_o.
//   slave  : axi_lite_channel slave modport (supplies clk and rstn)
//   regs_o : register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
// Build option: AXI_LITE_REGBANK_DECERR_EN -> out-of-range accesses answer
// DECERR; otherwise OKAY. Either way they write nothing and read 0.
module axi_lite_regbank
  import axi_common::*;
  import axi_lite_regbank_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 48,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  axi_lite_channel.slave                slave,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic clk, rstn;
  assign clk  = slave.clk;
  assign rstn = slave.rstn;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

  // Write holding registers
  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  b_valid;
  resp_t                 b_resp;
  logic                  r_valid;
  resp_t                 r_resp;
  logic [DATA_WIDTH-1:0] r_data;

  // ---------------- write path ----------------
  logic                  aw_hs, w_hs, aw_have, w_have, do_write;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;

  assign aw_hs   = slave.aw_valid && !aw_full;
  assign w_hs    = slave.w_valid  && !w_full;
  assign aw_have = aw_full || aw_hs;
  assign w_have  = w_full  || w_hs;

  // A beat arriving this cycle is used directly so a same-cycle AW+W pair
  // writes at its handshake edge; the holds only fill while B is stuck.
  assign wr_addr = aw_full ? aw_addr_q : slave.aw_addr;
  assign wr_data = w_full  ? w_data_q  : slave.w_data;
  assign wr_strb = w_full  ? w_strb_q  : slave.w_strb;

  // A write may retire on the same edge the pending B is accepted.
  assign do_write = aw_have && w_have && (!b_valid || slave.b_ready);

  axi_lite_regbank_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wr_dec (
    .addr     (wr_addr),
    .index    (wr_idx),
    .in_range (wr_in_range)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= slave.aw_addr;
      if (w_hs) begin
        w_data_q <= slave.w_data;
        w_strb_q <= slave.w_strb;
      end
      aw_full <= aw_have && !do_write;
      w_full  <= w_have  && !do_write;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_valid <= 1'b0;
      b_resp  <= OKAY;
    end else if (do_write) begin
      b_valid <= 1'b1;
      b_resp  <= wr_in_range ? OKAY : OOR_RESP;
    end else if (slave.b_ready) begin
      b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs_q <= '0;
    end else if (do_write && wr_in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (wr_strb[k]) regs_q[i][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // ---------------- read path ----------------
  logic             ar_hs;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;

  assign ar_hs = slave.ar_valid && !r_valid;

  axi_lite_regbank_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rd_dec (
    .addr     (slave.ar_addr),
    .index    (rd_idx),
    .in_range (rd_in_range)
  );

  // Samples regs_q before any same-edge write lands: read sees old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= OKAY;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= rd_in_range ? regs_q[rd_idx] : '0;
      r_resp  <= rd_in_range ? OKAY : OOR_RESP;
    end else if (slave.r_ready) begin
      r_valid <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign slave.aw_ready = !aw_full;
  assign slave.w_ready  = !w_full;
  assign slave.b_valid  = b_valid;
  assign slave.b_resp   = b_resp;
  assign slave.ar_ready = !r_valid;
  assign slave.r_valid  = r_valid;
  assign slave.r_data   = r_data;
  assign slave.r_resp   = r_resp;
  assign regs_o         = regs_q;

  logic unused_prot;
  assign unused_prot = ^{slave.aw_prot, slave.ar_prot};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank (DATA_WIDTH=64, NUM_REGS=16,
// BASE_ADDR=0). Expected B/R responses are queued at issue time and
// popped by a monitor on every B/R handshake.
module tb_axi_lite_regbank;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int NR = 16;
`ifdef AXI_LITE_REGBANK_DECERR_EN
  localparam logic [1:0] OOR = 2'b11;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (.clk(clk), .rstn(rstn));

  logic [NR*DW-1:0] regs_o;
  logic [NR*DW-1:0] exp_all;

  axi_lite_regbank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .BASE_ADDR  ('0)
  ) dut (
    .slave  (bus),
    .regs_o (regs_o)
  );

  logic [1:0] bq[$];
  rexp_t      rq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [47:0] a, input logic [63:0] d, input logic [7:0] s,
                    input logic [1:0] er);
    logic ad, wd;
    bq.push_back(er);
    bus.aw_addr = a; bus.w_data = d; bus.w_strb = s;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    for (int n = 0; n < 50 && (bus.aw_valid || bus.w_valid); n++) begin
      ad = bus.aw_valid && bus.aw_ready;
      wd = bus.w_valid && bus.w_ready;
      tick();
      if (ad) bus.aw_valid = 1'b0;
      if (wd) bus.w_valid = 1'b0;
    end
    chk("wr_accept", {62'd0, bus.aw_valid, bus.w_valid}, 64'd0);
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
  endtask

  task automatic rd(input logic [47:0] a, input logic [63:0] ed, input logic [1:0] er);
    rq.push_back('{data: ed, resp: er});
    bus.ar_addr = a;
    bus.ar_valid = 1'b1;
    for (int n = 0; n < 50 && !bus.ar_ready; n++) tick();
    chk("rd_accept", {63'd0, bus.ar_ready}, 64'd1);
    tick();
    bus.ar_valid = 1'b0;
    chk("rd_latency", {63'd0, bus.r_valid}, 64'd1);
  endtask

  // Monitor: every B/R handshake pops one expected response.
  initial begin
    logic [1:0] eb;
    rexp_t      er;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.b_valid && bus.b_ready) begin
          if (bq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL b_unexpected: got resp %h want no response", bus.b_resp);
          end else begin
            eb = bq.pop_front();
            chk("b_resp", 64'(bus.b_resp), 64'(eb));
          end
        end
        if (bus.r_valid && bus.r_ready) begin
          if (rq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL r_unexpected: got data %h want no response", bus.r_data);
          end else begin
            er = rq.pop_front();
            chk("r_data", bus.r_data, er.data);
            chk("r_resp", 64'(bus.r_resp), 64'(er.resp));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.w_valid = 0;  bus.w_data = '0;  bus.w_strb = '0;
    bus.b_ready = 1;
    bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_prot = '0;
    bus.r_ready = 1;
    exp_all = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b_valid", {63'd0, bus.b_valid}, 64'd0);
    chk("rst_r_valid", {63'd0, bus.r_valid}, 64'd0);
    chk("rst_b_resp", 64'(bus.b_resp), 64'd0);
    chk("rst_r_resp", 64'(bus.r_resp), 64'd0);
    chk("rst_r_data", bus.r_data, 64'd0);
    chk("rst_regs_zero", {63'd0, |regs_o}, 64'd0);
    rstn = 1'b1;
    chk("rst_readys", {61'd0, bus.aw_ready, bus.w_ready, bus.ar_ready}, 64'd7);

    // read of an untouched register
    rd(48'h0, 64'd0, 2'b00);
    tick();

    // same-cycle AW+W, full strobe
    wr(48'h8, 64'h1122334455667788, 8'hFF, 2'b00);
    exp_all[127:64] = 64'h1122334455667788;
    chk("wr_b_latency", {63'd0, bus.b_valid}, 64'd1);
    chk("wr_reg1", regs_o[127:64], 64'h1122334455667788);
    rd(48'h8, 64'h1122334455667788, 2'b00);
    tick();

    // W three cycles ahead of AW, low-half strobe
    bus.w_data = 64'hFFFFFFFFFFFFFFFF; bus.w_strb = 8'h0F; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    chk("w_held_ready", {63'd0, bus.w_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("w_only_no_b", {63'd0, bus.b_valid}, 64'd0);
      if (i < 2) tick();
    end
    bq.push_back(2'b00);
    bus.aw_addr = 48'h10; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    exp_all[191:128] = 64'h00000000FFFFFFFF;
    chk("late_aw_b", {63'd0, bus.b_valid}, 64'd1);
    chk("late_aw_reg2", regs_o[191:128], 64'h00000000FFFFFFFF);
    chk("late_aw_w_ready", {63'd0, bus.w_ready}, 64'd1);
    tick();

    // out-of-range write and read
    wr(48'h80, 64'hDEADBEEFDEADBEEF, 8'hFF, OOR);
    chk("oor_wr_noop", {63'd0, regs_o == exp_all}, 64'd1);
    rd(48'h80, 64'd0, OOR);
    tick();

    // B back-pressure with a second write queued behind it
    bus.b_ready = 1'b0;
    wr(48'h88, 64'h5555555555555555, 8'hFF, OOR);
    chk("bp_b_valid", {63'd0, bus.b_valid}, 64'd1);
    bq.push_back(2'b00);
    bus.aw_addr = 48'h20; bus.w_data = 64'hBBBBBBBBBBBBBBBB; bus.w_strb = 8'hFF;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    chk("bp_second_accepted", {62'd0, bus.aw_ready, bus.w_ready}, 64'd3);
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_holds_full", {62'd0, bus.aw_ready, bus.w_ready}, 64'd0);
      chk("bp_b_stable", {61'd0, bus.b_valid, bus.b_resp}, {61'd0, 1'b1, OOR});
      chk("bp_reg4_waits", regs_o[319:256], 64'd0);
      tick();
    end
    bus.b_ready = 1'b1;
    tick();
    exp_all[319:256] = 64'hBBBBBBBBBBBBBBBB;
    chk("bp_b_back2back", {61'd0, bus.b_valid, bus.b_resp}, {61'd0, 1'b1, 2'b00});
    chk("bp_reg4_done", regs_o[319:256], 64'hBBBBBBBBBBBBBBBB);
    chk("bp_readys", {62'd0, bus.aw_ready, bus.w_ready}, 64'd3);
    tick();

    // read and write of register 1 on the same edge: read sees old value
    rq.push_back('{data: 64'h1122334455667788, resp: 2'b00});
    bq.push_back(2'b00);
    bus.ar_addr = 48'h8; bus.ar_valid = 1'b1;
    bus.aw_addr = 48'h8; bus.aw_valid = 1'b1;
    bus.w_data = 64'hCAFEF00DDEADBEEF; bus.w_strb = 8'hF0; bus.w_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    exp_all[127:64] = 64'hCAFEF00D55667788;
    chk("rw_same_r_valid", {63'd0, bus.r_valid}, 64'd1);
    chk("rw_same_b_valid", {63'd0, bus.b_valid}, 64'd1);
    chk("rw_same_reg1", regs_o[127:64], 64'hCAFEF00D55667788);
    chk("regs_model", {63'd0, regs_o == exp_all}, 64'd1);
    tick();

    // reset while R is stalled and the W hold is full
    bus.r_ready = 1'b0;
    bus.ar_addr = 48'h10; bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    chk("mid_r_valid", {63'd0, bus.r_valid}, 64'd1);
    bus.w_data = 64'h0123456789ABCDEF; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    chk("mid_w_full", {62'd0, bus.w_ready, bus.ar_ready}, 64'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_r_valid", {63'd0, bus.r_valid}, 64'd0);
    chk("arst_b_valid", {63'd0, bus.b_valid}, 64'd0);
    chk("arst_r_data", bus.r_data, 64'd0);
    chk("arst_regs_zero", {63'd0, |regs_o}, 64'd0);
    chk("arst_w_ready", {63'd0, bus.w_ready}, 64'd1);
    bus.r_ready = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("post_rst_readys", {61'd0, bus.aw_ready, bus.w_ready, bus.ar_ready}, 64'd7);
    rd(48'h10, 64'd0, 2'b00);
    tick();
    rd(48'h8, 64'd0, 2'b00);

    repeat (3) tick();
    chk("b_queue_drained", 64'(bq.size()), 64'd0);
    chk("r_queue_drained", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
# axi_lite_regbank

AXI-Lite slave register bank that terminates one `axi_lite_channel` on its `slave` modport. It gives software a bank of NUM_REGS read/write registers and exports their current contents to the surrounding hardware. It sits behind an AXI-Lite interconnect port as the control/status block of a peripheral.

## Interface

Parameters:
- ADDR_WIDTH, 48: AXI-Lite address width; must match the connected channel.
- DATA_WIDTH, 64: register and bus width, 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
- NUM_REGS, 16: number of registers, at least 1.
- BASE_ADDR, 0: byte address of register 0; aligned to NUM_REGS*STRB_WIDTH rounded up to a power of 2.

Ports:
- clk  input  1  clock, taken from `slave.clk`; one clock domain.
- rstn  input  1  asynchronous active-low reset, taken from `slave.rstn`.
- slave  modport  `axi_lite_channel.slave`  AW/W/B/AR/R channels.
- regs_o  output  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation

- Decode:
  - offset = addr − BASE_ADDR.
  - index = offset >> log2(STRB_WIDTH); the low log2(STRB_WIDTH) address bits are ignored.
  - In range when addr ≥ BASE_ADDR and index < NUM_REGS.
- Write path:
  - AW and W are captured independently into one-entry holding registers.
  - Once both holding registers are full and no B is pending, the write is performed.
  - Byte lane k of the target register is updated only when w_strb[k] is 1.
  - b_resp is OKAY (2'b00), or the out-of-range response.
- Read path:
  - On an AR handshake, r_data is loaded with the register value (0 when out of range) and r_resp with OKAY or the out-of-range response.
- aw_prot and ar_prot are ignored.
- No EXOKAY response is ever generated.
- Reads and writes are fully independent and may complete in the same cycle.
- A read and a write to the same register in the same cycle: the read returns the pre-write value.

## Timing

- Reset values while rstn is low:
  - All registers, regs_o, b_valid and r_valid are 0.
  - b_resp, r_resp and r_data are 0.
  - Holding registers are empty.
- Ready signals are combinational from registered state:
  - aw_ready = AW holding register empty.
  - w_ready = W holding register empty.
  - ar_ready = !r_valid.
  - After reset, all three are 1.
- Write latency:
  - When AW and W handshake in cycle N, the register update and b_valid=1 occur at edge N+1.
  - The new value is visible on regs_o in cycle N+1.
  - When AW and W arrive in different cycles, the write occurs at the edge after the later of the two is held.
- B ordering:
  - b_valid holds, with b_resp stable, until b_ready is seen.
  - The holds clear when the write is performed, so the next AW/W can be accepted while B is pending.
  - The next write is not performed until the current B handshake completes.
  - b_valid clears on the handshake edge unless another write completes at that same edge; in that case b_valid stays 1 with the new response.
- Read latency:
  - An AR handshake in cycle N gives r_valid=1 in cycle N+1.
  - r_valid and r_data are held until r_ready is seen.
  - No new AR is accepted while r_valid is 1; maximum throughput is one read per 2 cycles.
- Reset asserted mid-transaction:
  - In-flight AW/W/B/AR/R state is discarded immediately and all registers return to 0.

## Configuration

- Macro AXI_LITE_REGBANK_DECERR_EN:
  - Defined: out-of-range accesses return DECERR (2'b11). Out-of-range writes modify nothing; out-of-range reads return r_data 0.
  - Undefined: out-of-range accesses return OKAY and behave the same way (write ignored, read data 0).

## Structure

- `resp_t`, its encodings (OKAY, EXOKAY, SLVERR, DECERR) and `prot_t` come from the shared `axi_common` package; no new typedefs are added.
- One sub-module is natural: `axi_lite_regbank_decode`, a combinational address → {index, in_range} decoder instantiated for both the AW and AR paths.

## Test plan

- Reset, then read 0x0 (DATA_WIDTH=64, BASE_ADDR=0) → r_valid one cycle after the AR handshake; r_data 0, r_resp OKAY.
- AW 0x8 and W 0x1122334455667788 with strb 0xFF in the same cycle → b_valid the next cycle, OKAY; regs_o[127:64] = 0x1122334455667788; read 0x8 returns the same value.
- W issued 3 cycles before AW to 0x10, strb 0x0F, data 0xFFFFFFFFFFFFFFFF → register 2 = 0x00000000FFFFFFFF; no B until AW is accepted.
- Write to 0x80 with NUM_REGS=16 → b_resp DECERR with the macro defined, OKAY without it; no register changes; reading 0x80 returns data 0 with the same response.
- b_ready held low 5 cycles while a second AW/W is sent → b_valid and b_resp stable; the second AW/W are accepted but the second write waits for the first B handshake; aw_ready and w_ready go low until the held write is performed.
- Assert rstn low while r_valid=1 and the W holding register is full → r_valid, b_valid and all registers go to 0 immediately; after rstn rises aw_ready=w_ready=ar_ready=1.
